// File: rtl/qbert_jump_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qbert_jump_sequencer_if : jump-command valid/ready channel, Rev 1.0|
// +--------------------------------------------------------------------+
interface qbert_jump_sequencer_if;
  logic       cmd_valid;
  logic [2:0] cmd_dir;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/qbert_jump_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qbert_jump_sequencer : jump FSM, cube colouring, lives/level, 1.0  |
// +--------------------------------------------------------------------+
module qbert_jump_sequencer #(
  parameter int N_CUBE       = 27,
  parameter int N_RANK       = 7,
  parameter int MOVE_TIMEOUT = 4095,
  parameter int LIVES_INIT   = 3
) (
  input  logic                  CLK_33,
  input  logic                  reset,
  qbert_jump_sequencer_if.slave cmd,
  input  logic                  restart,
  input  logic                  done_move,
  output logic                  nios_start_qbert,
  output logic [2:0]            qbert_jump,
  output logic                  bad_jump,
  output logic [4:0]            cube_idx,
  output logic [N_CUBE:0]       nios_top_color,
  output logic [4:0]            colored_cnt,
  output logic                  level_done,
  output logic [1:0]            lives,
  output logic                  game_over
);
  localparam int TW = $clog2(MOVE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    MOVE   = 3'd2,
    LAND   = 3'd3,
    FALL   = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_rank, r_col, r_tgt_rank, r_tgt_col;
  logic [3:0]    w_tr, w_tc;
  logic [TW-1:0] r_timer;
  logic [4:0]    w_base, w_tgt_idx;
  logic          r_cmd_ready, w_dir_ok, w_off, w_accept, w_move_end;
  logic          w_new_bit, w_land_done;

  assign cmd.cmd_ready = r_cmd_ready;
  assign w_accept      = cmd.cmd_valid && r_cmd_ready;

  // Target in 4 bits so rank 0 / rank 8 remain distinguishable for the range check
  always_comb begin
    w_dir_ok = 1'b1;
    w_tr     = {1'b0, r_rank};
    w_tc     = {1'b0, r_col};
    case (cmd.cmd_dir)
      3'd1: w_tr = {1'b0, r_rank} - 4'd1;
      3'd2: begin
        w_tr = {1'b0, r_rank} - 4'd1;
        w_tc = {1'b0, r_col} - 4'd1;
      end
      3'd3: begin
        w_tr = {1'b0, r_rank} + 4'd1;
        w_tc = {1'b0, r_col} + 4'd1;
      end
      3'd4: w_tr = {1'b0, r_rank} + 4'd1;
      default: w_dir_ok = 1'b0;
    endcase
    w_off = (w_tr == 4'd0) || (w_tr > 4'(N_RANK)) || (w_tc == 4'd0) || (w_tc > w_tr);
  end

  // First index of each rank, r(r-1)/2
  always_comb begin
    case (r_tgt_rank)
      3'd2:    w_base = 5'd1;
      3'd3:    w_base = 5'd3;
      3'd4:    w_base = 5'd6;
      3'd5:    w_base = 5'd10;
      3'd6:    w_base = 5'd15;
      3'd7:    w_base = 5'd21;
      default: w_base = 5'd0;
    endcase
  end

  assign w_tgt_idx   = w_base + {2'b00, r_tgt_col} - 5'd1;
  assign w_new_bit   = !nios_top_color[w_tgt_idx];
  assign w_land_done = w_new_bit && (colored_cnt == 5'(N_CUBE));
  assign w_move_end  = done_move || (r_timer == TW'(MOVE_TIMEOUT));

  always_comb begin
    w_next = r_state;
    if (restart) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept && w_dir_ok) w_next = LAUNCH;
        LAUNCH:  w_next = MOVE;
        MOVE:    if (w_move_end) w_next = bad_jump ? FALL : LAND;
        LAND:    w_next = w_land_done ? HALT : IDLE;
        FALL:    w_next = (lives <= 2'd1) ? HALT : IDLE;
        HALT:    w_next = HALT;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      r_rank           <= 3'd1;
      r_col            <= 3'd1;
      r_tgt_rank       <= 3'd1;
      r_tgt_col        <= 3'd1;
      r_timer          <= '0;
      r_cmd_ready      <= 1'b1;
      cube_idx         <= 5'd0;
      nios_top_color   <= {{N_CUBE{1'b0}}, 1'b1};
      colored_cnt      <= 5'd1;
      lives            <= 2'(LIVES_INIT);
      level_done       <= 1'b0;
      game_over        <= 1'b0;
      nios_start_qbert <= 1'b0;
      qbert_jump       <= 3'd0;
      bad_jump         <= 1'b0;
    end else if (restart) begin
      r_rank           <= 3'd1;
      r_col            <= 3'd1;
      r_tgt_rank       <= 3'd1;
      r_tgt_col        <= 3'd1;
      r_timer          <= '0;
      r_cmd_ready      <= 1'b1;
      cube_idx         <= 5'd0;
      nios_top_color   <= {{N_CUBE{1'b0}}, 1'b1};
      colored_cnt      <= 5'd1;
      lives            <= 2'(LIVES_INIT);
      level_done       <= 1'b0;
      game_over        <= 1'b0;
      nios_start_qbert <= 1'b0;
      qbert_jump       <= 3'd0;
      bad_jump         <= 1'b0;
    end else begin
      nios_start_qbert <= 1'b0;
      r_cmd_ready      <= (w_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept && w_dir_ok) begin
            qbert_jump       <= cmd.cmd_dir;
            bad_jump         <= w_off;
            r_tgt_rank       <= w_tr[2:0];
            r_tgt_col        <= w_tc[2:0];
            nios_start_qbert <= 1'b1;
          end
        end
        LAUNCH: r_timer <= TW'(1);
        MOVE:   r_timer <= r_timer + TW'(1);
        LAND: begin
          r_rank     <= r_tgt_rank;
          r_col      <= r_tgt_col;
          cube_idx   <= w_tgt_idx;
          qbert_jump <= 3'd0;
          bad_jump   <= 1'b0;
          if (w_new_bit) begin
            nios_top_color[w_tgt_idx] <= 1'b1;
            colored_cnt               <= colored_cnt + 5'd1;
          end
          if (w_land_done) level_done <= 1'b1;
        end
        FALL: begin
          r_rank     <= 3'd1;
          r_col      <= 3'd1;
          cube_idx   <= 5'd0;
          qbert_jump <= 3'd0;
          bad_jump   <= 1'b0;
          if (lives != 2'd0) lives <= lives - 2'd1;
          if (lives <= 2'd1) game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_qbert_jump_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_qbert_jump_sequencer : randomized bench with pyramid model, 1.0 |
// +--------------------------------------------------------------------+
module tb_qbert_jump_sequencer;
  logic        CLK_33 = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic        done_move = 1'b0;
  logic        nios_start_qbert;
  logic [2:0]  qbert_jump;
  logic        bad_jump;
  logic [4:0]  cube_idx;
  logic [27:0] nios_top_color;
  logic [4:0]  colored_cnt;
  logic        level_done;
  logic [1:0]  lives;
  logic        game_over;

  int tests = 0;
  int fails = 0;

  // Reference model state: position, coloured set, lives, flags
  int          m_r, m_c, m_lives, m_cnt;
  logic [27:0] m_map;
  bit          m_level, m_over;

  qbert_jump_sequencer_if cif();

  qbert_jump_sequencer dut (
    .CLK_33           (CLK_33),
    .reset            (reset),
    .cmd              (cif),
    .restart          (restart),
    .done_move        (done_move),
    .nios_start_qbert (nios_start_qbert),
    .qbert_jump       (qbert_jump),
    .bad_jump         (bad_jump),
    .cube_idx         (cube_idx),
    .nios_top_color   (nios_top_color),
    .colored_cnt      (colored_cnt),
    .level_done       (level_done),
    .lives            (lives),
    .game_over        (game_over)
  );

  always #15 CLK_33 = ~CLK_33;

  function automatic int cidx(input int r, input int c);
    return r * (r - 1) / 2 + c - 1;
  endfunction

  task automatic model_reset();
    m_r = 1; m_c = 1; m_lives = 3; m_cnt = 1;
    m_map = 28'h1; m_level = 0; m_over = 0;
  endtask

  task automatic model_target(input int dir, output int tr, output int tc, output bit off);
    tr = (dir >= 3) ? m_r + 1 : m_r - 1;
    tc = (dir == 2) ? m_c - 1 : (dir == 3) ? m_c + 1 : m_c;
    off = (tr < 1) || (tr > 7) || (tc < 1) || (tc > tr);
  endtask

  task automatic model_complete(input bit off, input int tr, input int tc);
    if (off) begin
      if (m_lives > 0) m_lives--;
      m_r = 1; m_c = 1;
      if (m_lives == 0) m_over = 1;
    end else begin
      m_r = tr; m_c = tc;
      if (!m_map[cidx(tr, tc)]) begin
        m_map[cidx(tr, tc)] = 1'b1;
        m_cnt++;
      end
      if (m_cnt == 28) m_level = 1;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge CLK_33);
    restart = 1'b0;
    model_reset();
  endtask

  task automatic run_jump(input int dir, input int delay);
    int tr, tc;
    bit off, hold_ok;
    model_target(dir, tr, tc, off);
    tests++;
    if (cif.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL jump_ready: cmd_ready=%b required 1", cif.cmd_ready);
    end
    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'(dir);
    @(negedge CLK_33);
    cif.cmd_valid = 1'b0;
    tests++;
    if (nios_start_qbert !== 1'b1 || qbert_jump !== 3'(dir) || bad_jump !== off) begin
      fails++;
      $display("FAIL jump_launch: start=%b dir=%0d bad=%b required 1 %0d %b",
               nios_start_qbert, qbert_jump, bad_jump, dir, off);
    end
    hold_ok = 1;
    for (int i = 0; i < delay; i++) begin
      @(negedge CLK_33);
      if (nios_start_qbert !== 1'b0 || qbert_jump !== 3'(dir) || bad_jump !== off ||
          cif.cmd_ready !== 1'b0) hold_ok = 0;
    end
    tests++;
    if (!hold_ok) begin
      fails++; $display("FAIL jump_hold: outputs not held during move, dir=%0d required %0d", qbert_jump, dir);
    end
    done_move = 1'b1;
    @(negedge CLK_33);
    done_move = 1'b0;
    @(negedge CLK_33);
    model_complete(off, tr, tc);
    tests++;
    if (cube_idx !== 5'(cidx(m_r, m_c)) || nios_top_color !== m_map || colored_cnt !== 5'(m_cnt) ||
        lives !== 2'(m_lives) || game_over !== m_over || level_done !== m_level ||
        cif.cmd_ready !== !(m_over || m_level) || qbert_jump !== 3'd0 || bad_jump !== 1'b0) begin
      fails++;
      $display("FAIL jump_land: idx=%0d map=%h cnt=%0d lives=%0d go=%b ld=%b rdy=%b required %0d %h %0d %0d %b %b %b",
               cube_idx, nios_top_color, colored_cnt, lives, game_over, level_done, cif.cmd_ready,
               cidx(m_r, m_c), m_map, m_cnt, m_lives, m_over, m_level, !(m_over || m_level));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK_33);
    reset = 1'b1;
    model_reset();
    @(negedge CLK_33);
    tests++;
    if (cube_idx !== 5'd0 || nios_top_color !== 28'h1 || colored_cnt !== 5'd1 || lives !== 2'd3 ||
        cif.cmd_ready !== 1'b1 || game_over !== 1'b0 || level_done !== 1'b0 ||
        nios_start_qbert !== 1'b0 || qbert_jump !== 3'd0 || bad_jump !== 1'b0) begin
      fails++;
      $display("FAIL reset: idx=%0d map=%h cnt=%0d lives=%0d rdy=%b required 0 0000001 1 3 1",
               cube_idx, nios_top_color, colored_cnt, lives, cif.cmd_ready);
    end
  endtask

  task automatic test_legal_jump();
    run_jump(3, 10);
    tests++;
    if (cube_idx !== 5'd2 || nios_top_color !== 28'h5 || colored_cnt !== 5'd2) begin
      fails++;
      $display("FAIL legal_jump: idx=%0d map=%h cnt=%0d required 2 0000005 2", cube_idx, nios_top_color, colored_cnt);
    end
  endtask

  task automatic test_off_pyramid();
    pulse_restart();
    for (int k = 0; k < 3; k++) run_jump(1, 4);
    tests++;
    if (lives !== 2'd0 || game_over !== 1'b1 || cif.cmd_ready !== 1'b0 || nios_top_color !== 28'h1) begin
      fails++;
      $display("FAIL off_pyramid: lives=%0d go=%b rdy=%b map=%h required 0 1 0 0000001",
               lives, game_over, cif.cmd_ready, nios_top_color);
    end
  endtask

  task automatic test_timeout_revisit();
    int tr, tc, n;
    bit off;
    pulse_restart();
    model_target(3, tr, tc, off);
    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd3;
    @(negedge CLK_33);
    cif.cmd_valid = 1'b0;
    tests++;
    if (nios_start_qbert !== 1'b1 || bad_jump !== 1'b0) begin
      fails++; $display("FAIL timeout_launch: start=%b bad=%b required 1 0", nios_start_qbert, bad_jump);
    end
    n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge CLK_33);
      n++;
    end
    // Launch cycle, 4095 MOVE cycles, LAND, then ready
    tests++;
    if (n != 4097) begin
      fails++; $display("FAIL timeout_len: ready after %0d cycles required 4097", n);
    end
    model_complete(off, tr, tc);
    tests++;
    if (cube_idx !== 5'(cidx(m_r, m_c)) || nios_top_color !== m_map || colored_cnt !== 5'(m_cnt)) begin
      fails++;
      $display("FAIL timeout_land: idx=%0d map=%h cnt=%0d required %0d %h %0d",
               cube_idx, nios_top_color, colored_cnt, cidx(m_r, m_c), m_map, m_cnt);
    end
    run_jump(2, 3);
    tests++;
    if (colored_cnt !== 5'd2 || cube_idx !== 5'd0) begin
      fails++; $display("FAIL revisit: cnt=%0d idx=%0d required 2 0", colored_cnt, cube_idx);
    end
  endtask

  task automatic test_full_map();
    int path[$];
    bit none;
    pulse_restart();
    path = {4, 4, 4, 4, 4, 4, 1, 3, 1, 1, 1, 1, 1, 3, 4, 4, 4, 4, 1, 3, 1, 1, 1, 3, 4, 4, 1, 3, 1, 3};
    foreach (path[i]) run_jump(path[i], 1 + (i % 3));
    tests++;
    if (level_done !== 1'b1 || nios_top_color !== 28'hFFFFFFF || colored_cnt !== 5'd28) begin
      fails++;
      $display("FAIL full_map: ld=%b map=%h cnt=%0d required 1 fffffff 28", level_done, nios_top_color, colored_cnt);
    end
    none = 1;
    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd1;
    repeat (5) begin
      @(negedge CLK_33);
      if (nios_start_qbert !== 1'b0 || cif.cmd_ready !== 1'b0) none = 0;
    end
    cif.cmd_valid = 1'b0;
    tests++;
    if (!none) begin
      fails++; $display("FAIL halt_block: start=%b rdy=%b required 0 0", nios_start_qbert, cif.cmd_ready);
    end
  endtask

  task automatic test_restart_illegal();
    int dirs[3];
    bit quiet;
    pulse_restart();
    dirs = '{0, 7, 5};
    foreach (dirs[i]) begin
      cif.cmd_valid = 1'b1; cif.cmd_dir = 3'(dirs[i]);
      @(negedge CLK_33);
      cif.cmd_valid = 1'b0;
      @(negedge CLK_33);
      tests++;
      if (nios_start_qbert !== 1'b0 || cube_idx !== 5'd0 || nios_top_color !== m_map ||
          lives !== 2'(m_lives) || qbert_jump !== 3'd0 || cif.cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL illegal_dir: dir=%0d start=%b idx=%0d qj=%0d rdy=%b required 0 0 0 1",
                 dirs[i], nios_start_qbert, cube_idx, qbert_jump, cif.cmd_ready);
      end
    end
    done_move = 1'b1;
    @(negedge CLK_33);
    done_move = 1'b0;
    @(negedge CLK_33);
    tests++;
    if (cif.cmd_ready !== 1'b1 || cube_idx !== 5'd0 || lives !== 2'(m_lives) || colored_cnt !== 5'(m_cnt)) begin
      fails++; $display("FAIL stray_done: rdy=%b idx=%0d lives=%0d required 1 0 %0d", cif.cmd_ready, cube_idx, lives, m_lives);
    end
    // Accept a move, abandon it mid-MOVE with restart plus a competing command
    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd3;
    @(negedge CLK_33);
    cif.cmd_valid = 1'b0;
    repeat (3) @(negedge CLK_33);
    restart = 1'b1; cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd4;
    @(negedge CLK_33);
    restart = 1'b0; cif.cmd_valid = 1'b0;
    model_reset();
    tests++;
    if (cube_idx !== 5'd0 || nios_top_color !== 28'h1 || colored_cnt !== 5'd1 || lives !== 2'd3 ||
        cif.cmd_ready !== 1'b1 || qbert_jump !== 3'd0 || bad_jump !== 1'b0 || nios_start_qbert !== 1'b0) begin
      fails++;
      $display("FAIL restart_move: idx=%0d map=%h cnt=%0d lives=%0d rdy=%b qj=%0d required 0 0000001 1 3 1 0",
               cube_idx, nios_top_color, colored_cnt, lives, cif.cmd_ready, qbert_jump);
    end
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      done_move = (i == 2);
      @(negedge CLK_33);
      if (nios_start_qbert !== 1'b0 || cube_idx !== 5'd0 || cif.cmd_ready !== 1'b1) quiet = 0;
    end
    done_move = 1'b0;
    tests++;
    if (!quiet) begin
      fails++; $display("FAIL restart_quiet: start=%b idx=%0d required 0 0", nios_start_qbert, cube_idx);
    end
  endtask

  task automatic test_random();
    int d;
    for (int k = 0; k < 80; k++) begin
      if (m_over || m_level) pulse_restart();
      if ($urandom_range(0, 7) == 0) begin
        d = $urandom_range(5, 8);
        if (d == 8) d = 0;
        cif.cmd_valid = 1'b1; cif.cmd_dir = 3'(d);
        @(negedge CLK_33);
        cif.cmd_valid = 1'b0;
        tests++;
        if (nios_start_qbert !== 1'b0 || cube_idx !== 5'(cidx(m_r, m_c)) || cif.cmd_ready !== 1'b1) begin
          fails++;
          $display("FAIL rand_illegal: dir=%0d start=%b idx=%0d required 0 %0d", d, nios_start_qbert, cube_idx, cidx(m_r, m_c));
        end
      end else begin
        run_jump($urandom_range(1, 4), $urandom_range(1, 12));
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_dir   = 3'd0;
    test_reset();
    test_legal_jump();
    test_off_pyramid();
    test_timeout_revisit();
    test_full_map();
    test_restart_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/qbert_jump_sequencer.md
Name: qbert_jump_sequencer

Overview:
- Game-side controller for the cube map and Qbert sprite datapath.
- Accepts jump commands from the Avalon/NIOS side through a valid/ready handshake, and tracks Qbert's (rank, column) on the 7-rank pyramid.
- Launches each move on the sprite layer (start pulse, direction, bad_jump) and waits for done_move.
- On landing, updates the 28-bit top-colour vector that drives the cube colouring, counts coloured cubes, and manages lives, level-complete and game-over.

Parameters:
N_cube, 27, highest cube index (28 cubes, indices 0..27).
N_rank, 7, number of pyramid ranks.
MOVE_TIMEOUT, 4095, cycles to wait for done_move before forcing completion.
LIVES_INIT, 3, lives loaded at reset and on restart.

Ports:
CLK_33  in  1  system clock (33 MHz pixel clock domain).
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  jump command present.
cmd_dir  in  3  direction: 1 up-right, 2 up-left, 3 down-right, 4 down-left; others illegal.
cmd_ready  out  1  sequencer can accept a command.
restart  in  1  one-cycle pulse: new level, clears map, Qbert back to cube 0.
done_move  in  1  pulse from the sprite layer: animation finished.
nios_start_qbert  out  1  one-cycle launch pulse to the sprite layer.
qbert_jump  out  3  direction held stable from launch through done_move.
bad_jump  out  1  high during a move whose target is off the pyramid.
cube_idx  out  5  index of the cube Qbert occupies (0..27).
nios_top_color  out  N_cube+1  bit i set means cube i has been coloured.
colored_cnt  out  5  number of set bits in nios_top_color.
level_done  out  1  all 28 cubes coloured; sticky until restart.
lives  out  2  remaining lives.
game_over  out  1  lives reached 0; sticky until restart.

Behaviour:
- Reset (async assert, sync release) and restart share the same targets:
  - rank=1, col=1, cube_idx=0.
  - nios_top_color = 0x0000001 (start cube coloured); colored_cnt=1.
  - lives = LIVES_INIT.
  - All pulses and flags 0; qbert_jump=0; state IDLE.
- Geometry: cube (r,c) with 1≤c≤r≤7 has index r(r-1)/2 + c-1, computed with a combinational table over r (no multiplier).
- Targets by direction:
  - up-right (r-1,c); up-left (r-1,c-1); down-right (r+1,c+1); down-left (r+1,c).
  - A target is off-pyramid if r'<1, r'>7, c'<1 or c'>r'.
- States: IDLE, LAUNCH, MOVE, LAND, FALL, HALT.
- IDLE:
  - cmd_ready = 1 only in IDLE, and only when level_done=0 and game_over=0.
  - Command accepted on cmd_valid & cmd_ready.
  - Illegal dir: dropped, state stays IDLE, nothing else changes.
  - Legal dir: latch dir into qbert_jump, latch target, set bad_jump = off-pyramid; go to LAUNCH.
- LAUNCH: nios_start_qbert=1 for exactly one cycle; go to MOVE.
- MOVE:
  - Wait for done_move; a timeout counter counts cycles in MOVE.
  - On done_move, or when the counter reaches MOVE_TIMEOUT: go to FALL if bad_jump, else LAND.
- LAND:
  - Single cycle; rank/col/cube_idx take the target.
  - If the target bit is 0: set it and increment colored_cnt.
  - If colored_cnt becomes 28: set level_done.
  - Go to HALT if level_done, else IDLE.
- FALL:
  - Single cycle; lives decrements, saturating at 0.
  - Qbert returns to (1,1); the map is not cleared.
  - If lives becomes 0: set game_over, go to HALT; else go to IDLE.
- HALT: cmd_ready=0; only restart (or reset) exits, to IDLE with the reset values above.
- Outputs and timing:
  - bad_jump and qbert_jump are held from acceptance until the cycle after LAND/FALL, then cleared to 0.
  - Minimum command-to-command spacing is 4 cycles (accept, LAUNCH, MOVE≥1, LAND/FALL); cmd_ready rises the cycle after LAND/FALL.
- Boundary conditions:
  - done_move outside MOVE is ignored.
  - done_move in the same cycle as the timeout expiry counts as one completion.
  - restart in any state has priority over every transition; the in-flight move is abandoned and no start pulse is issued.
  - cmd_valid together with restart: the command is dropped.
  - Landing on an already-coloured cube leaves the vector and count unchanged.
- Registered outputs only; colored_cnt width is 5 and it never exceeds 28.

Test Plan:
- Reset: deassert reset → cube_idx=0, nios_top_color=0x0000001, colored_cnt=1, lives=3, cmd_ready=1.
- Legal jump: dir=3 from (1,1), done_move 10 cycles after the start pulse → one start pulse, qbert_jump=3 during the move, cube_idx=2, bit 2 set, colored_cnt=2.
- Off-pyramid jump: dir=1 from (1,1) → bad_jump=1 through the move; after done_move lives=2, cube_idx=0, map unchanged. Three such jumps → lives=0, game_over=1, cmd_ready=0.
- Timeout and revisit: withhold done_move → move completes after exactly 4095 cycles in MOVE. Revisit a coloured cube → colored_cnt unchanged.
- Full map: drive a path covering all 28 cubes → level_done=1 on the landing that sets the 28th bit, nios_top_color=0xFFFFFFF, further cmd_valid not accepted.
- Restart and illegal direction: pulse restart mid-MOVE → no further start pulse, state IDLE, reset values restored. Illegal dir=0 or 7 is dropped with no outputs changing.
